// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and helpers for the serial pattern detector
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_t;

    localparam int          DEF_PAT_W   = 4;
    localparam logic [3:0]  DEF_PAT_VAL = 4'b1010;

    // Lengths outside 1..max_len select the full pattern width.
    function automatic int clamp_len(input int len_v, input int max_len);
        if (len_v < 1 || len_v > max_len) begin
            return max_len;
        end
        return len_v;
    endfunction

endpackage

// File: rtl/seq_det_match_cmp.sv
// rtl/seq_det_match_cmp.sv - masked comparator of history against the low len pattern bits
module seq_det_match_cmp
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LW    = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat,
    input  logic [LW-1:0]    len,
    output logic             eq
);

    logic [PAT_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (len > LW'(i));
        end
    end

    assign eq = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable serial pattern detector with Mealy/Moore outputs and match counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PAT_VAL),
    parameter int               CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_seq,
    input  logic                       overlap_en,
    input  logic                       pattern_load,
    input  logic [PAT_W-1:0]           pattern_in,
    input  logic [$clog2(PAT_W+1)-1:0] len_in,
    input  logic                       count_clr,
    output logic                       match_mealy,
    output logic                       out_detect,
    output logic [CNT_W-1:0]           match_count
);

    localparam int LW = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    det_state_t       state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d, next_hist;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d, len_clamped;
    logic [LW-1:0]    fill_q, fill_d, fill_sat;
    logic [CNT_W-1:0] count_d;
    logic             armed_next, eq;

    assign next_hist   = {hist_q[PAT_W-2:0], in_seq};
    assign len_clamped = LW'(clamp_len(int'(len_in), PAT_W));
    assign fill_sat    = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
    assign armed_next  = (fill_sat == len_q);

    seq_det_match_cmp #(
        .PAT_W (PAT_W),
        .LW    (LW)
    ) u_cmp (
        .hist (next_hist),
        .pat  (pat_q),
        .len  (len_q),
        .eq   (eq)
    );

    // A load cycle discards its bit, and reset suppresses any match.
    assign match_mealy = !rst && in_valid && !pattern_load && armed_next && eq;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        count_d = match_count;

        if (pattern_load) begin
            pat_d   = pattern_in;
            len_d   = len_clamped;
            fill_d  = '0;
            state_d = FILL;
        end else if (in_valid) begin
            hist_d  = next_hist;
            fill_d  = fill_sat;
            state_d = armed_next ? ARMED : FILL;
            if (match_mealy && !overlap_en) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end

        if (count_clr) begin
            count_d = '0;
        end else if (match_mealy && match_count != CNT_MAX) begin
            count_d = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= DEF_PATTERN;
            len_q       <= LW'(PAT_W);
            out_detect  <= 1'b0;
            match_count <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            out_detect  <= match_mealy;
            match_count <= count_d;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - table-driven bench for seq_detector_param
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_seq, overlap_en, pattern_load, count_clr;
    logic [3:0] pattern_in;
    logic [2:0] len_in;
    logic       match_mealy, out_detect;
    logic [1:0] match_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       r, v, s, o, l;
        logic [3:0] pi;
        logic [2:0] li;
        logic       c;
        logic       em, ed;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W       (4),
        .DEF_PATTERN (4'b1010),
        .CNT_W       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_seq       (in_seq),
        .overlap_en   (overlap_en),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .len_in       (len_in),
        .count_clr    (count_clr),
        .match_mealy  (match_mealy),
        .out_detect   (out_detect),
        .match_count  (match_count)
    );

    task automatic add(input logic r, v, s, o, l, input logic [3:0] pi, input logic [2:0] li,
                       input logic c, em, ed, input logic [1:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.o = o; t.l = l; t.pi = pi; t.li = li;
        t.c = c; t.em = em; t.ed = ed; t.ec = ec;
        vecs.push_back(t);
    endtask

    task automatic rstv();
        add(1, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 2'd0);
    endtask

    task automatic bt(input logic s, o, em, input logic [1:0] ec);
        add(0, 1, s, o, 0, 4'd0, 3'd0, 0, em, em, ec);
    endtask

    task automatic idle(input logic [1:0] ec);
        add(0, 0, 0, 1, 0, 4'd0, 3'd0, 0, 0, 0, ec);
    endtask

    task automatic load(input logic [3:0] pi, input logic [2:0] li, input logic s, input logic [1:0] ec);
        add(0, 1, s, 1, 1, pi, li, 0, 0, 0, ec);
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst = t.r; in_valid = t.v; in_seq = t.s; overlap_en = t.o; pattern_load = t.l;
        pattern_in = t.pi; len_in = t.li; count_clr = t.c;
        #1;
        check("match_mealy", idx, {1'b0, match_mealy}, {1'b0, t.em});
        @(posedge clk);
        #1;
        check("out_detect", idx, {1'b0, out_detect}, {1'b0, t.ed});
        check("match_count", idx, match_count, t.ec);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_seq = 1'b0; overlap_en = 1'b0;
        pattern_load = 1'b0; pattern_in = '0; len_in = '0; count_clr = 1'b0;

        // overlap on, default 1010
        rstv();
        bt(1,1,0,0); bt(0,1,0,0); bt(1,1,0,0); bt(0,1,1,1); bt(1,1,0,1); bt(0,1,1,2);
        idle(2);
        // overlap off
        rstv();
        bt(1,0,0,0); bt(0,0,0,0); bt(1,0,0,0); bt(0,0,1,1); bt(1,0,0,1); bt(0,0,0,1);
        // runtime load of 110 with a bit in the load cycle, then gapped stream
        rstv();
        load(4'b0110, 3'd3, 1'b1, 2'd0);
        bt(1,1,0,0); idle(0); bt(1,1,0,0); bt(0,1,1,1); idle(1);
        bt(1,1,0,1); bt(1,1,0,1); idle(1); bt(0,1,1,2);
        // reset mid-pattern; the bit under reset would otherwise complete 1010
        rstv();
        bt(1,1,0,0); bt(0,1,0,0); bt(1,1,0,0);
        add(1, 1, 0, 1, 0, 4'd0, 3'd0, 0, 0, 0, 2'd0);
        bt(0,1,0,0); bt(1,1,0,0); bt(0,1,0,0); bt(1,1,0,0); bt(0,1,1,1);
        // saturation at 3, then clear beating a coincident match
        rstv();
        bt(1,1,0,0); bt(0,1,0,0); bt(1,1,0,0); bt(0,1,1,1);
        bt(1,1,0,1); bt(0,1,1,2); bt(1,1,0,2); bt(0,1,1,3);
        bt(1,1,0,3); bt(0,1,1,3); bt(1,1,0,3); bt(0,1,1,3);
        bt(1,1,0,3);
        add(0, 1, 0, 1, 0, 4'd0, 3'd0, 1, 1, 1, 2'd0);
        bt(1,1,0,0); bt(0,1,1,1);
        // length 1, then len_in=0 clamps to 4
        rstv();
        load(4'b0001, 3'd1, 1'b0, 2'd0);
        bt(1,1,1,1); bt(1,1,1,2); bt(0,1,0,2); bt(1,1,1,3);
        load(4'b1010, 3'd0, 1'b0, 2'd3);
        add(1, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0, 2'd0);
        load(4'b1010, 3'd0, 1'b0, 2'd0);
        bt(1,1,0,0); bt(0,1,0,0); bt(1,1,0,0); bt(0,1,1,1);
        // len_in=7 clamps to 4
        load(4'b0011, 3'd7, 1'b0, 2'd1);
        bt(0,1,0,1); bt(0,1,0,1); bt(1,1,0,1); bt(1,1,1,2);

        foreach (vecs[i]) apply(vecs[i], i);

        // hand sequence: pattern 11 overlapping gives back-to-back out_detect
        vecs.delete();
        rstv();
        load(4'b0011, 3'd2, 1'b1, 2'd0);
        bt(1,1,0,0); bt(1,1,1,1); bt(1,1,1,2); bt(1,1,1,3); idle(3);
        foreach (vecs[i]) apply(vecs[i], 1000 + i);

        // hand sequence: 11 non-overlapping matches every second bit
        vecs.delete();
        rstv();
        load(4'b0011, 3'd2, 1'b0, 2'd0);
        bt(1,0,0,0); bt(1,0,1,1); bt(1,0,0,1); bt(1,0,1,2);
        // overlap_en change applies to the bit of that same cycle
        bt(1,1,0,2); bt(1,1,1,3); bt(1,0,1,3); bt(1,1,0,3);
        foreach (vecs[i]) apply(vecs[i], 2000 + i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
